cart_dump_ctrl: RTL and testbench

Sequences a complete cartridge ROM dump. The block re-arms and launches the dump engine, captures each 16-bit word on the engine's one-cycle data_ready strobe, and serialises each word into two bytes (low byte first). The bytes pass through a small FIFO to a byte-wide valid/ready transmit sink (UART TX). It sits between the host command decoder and the dump engine/UART. It reports progress, completion and data loss; the engine has no backpressure, so dropped data is flagged, never stalled.

---
 rtl/cart_dump_pkg.sv | 24 ++
 rtl/dump_byte_fifo.sv | 66 ++++++
 rtl/cart_dump_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cart_dump_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_dump_pkg.sv
// Shared types and constants for the cartridge dump controller slice.
package cart_dump_pkg;

    localparam int WORD_W             = 16;
    localparam int BYTE_W             = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int DEFAULT_ARM_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Select the low or high byte of a captured cartridge word.
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic              hi);
        return hi ? w[WORD_W-1:BYTE_W] : w[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/dump_byte_fifo.sv
// Synchronous single-clock FIFO with flush; head entry is presented
// combinationally from the storage array and forced to zero when empty.
module dump_byte_fifo
    import cart_dump_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = BYTE_W
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal alongside it.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards all entries.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates the output.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cart_dump_ctrl.sv
// Cartridge dump sequencer: re-arms and launches the dump engine, captures
// words into a holding register, splits them low byte first into a byte FIFO
// feeding the UART transmitter, and flags words lost to backpressure.
module cart_dump_ctrl
    import cart_dump_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ARM_CYCLES = DEFAULT_ARM_CYCLES
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    output logic              eng_n_reset,
    output logic              eng_start,
    input  logic              eng_data_ready,
    input  logic              eng_done,
    input  logic [WORD_W-1:0] ad_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [23:0]       word_count
);

    localparam int ACW = $clog2(ARM_CYCLES + 1);
    localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_CYCLES - 1);

    state_t                    state;
    logic [ACW-1:0]            arm_cnt;
    logic                      abort_pend;

    logic                      hold_valid;
    logic                      hold_hi;
    logic [WORD_W-1:0]         hold_word;

    logic                      fifo_push;
    logic                      fifo_flush;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic                      active;
    logic                      start_go;
    logic                      abort_go;
    logic                      hold_free;
    logic                      word_in;
    logic                      accept;
    logic                      drop;

    assign active   = (state == ARM) || (state == LAUNCH) || (state == RUN) || (state == DRAIN);
    assign abort_go = cmd_abort && active;
    // An abort pulse coincident with start suppresses the start.
    assign start_go = cmd_start && !cmd_abort && ((state == IDLE) || (state == DONE));

    assign fifo_flush = abort_go || start_go;
    assign fifo_push  = hold_valid && !fifo_full && !abort_go;
    // The register frees itself in the cycle its high byte leaves, so a word can land then.
    assign hold_free  = !hold_valid || (fifo_push && hold_hi);
    assign word_in    = (state == RUN) && eng_data_ready && !abort_go;
    assign accept     = word_in && hold_free;
    assign drop       = word_in && !hold_free;

    assign tx_valid = !fifo_empty;

    dump_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (word_byte(hold_word, hold_hi)),
        .pop       (tx_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (tx_data)
    );

    // Sequencer FSM with registered engine controls and status flags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            arm_cnt     <= '0;
            abort_pend  <= 1'b0;
            eng_n_reset <= 1'b1;
            eng_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort_go) begin
            state       <= ARM;
            arm_cnt     <= '0;
            abort_pend  <= 1'b1;
            eng_n_reset <= 1'b0;
            eng_start   <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_go) begin
                        state       <= ARM;
                        arm_cnt     <= '0;
                        abort_pend  <= 1'b0;
                        eng_n_reset <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ARM: begin
                    if (arm_cnt == ARM_LAST) begin
                        arm_cnt     <= '0;
                        eng_n_reset <= 1'b1;
                        if (abort_pend) begin
                            state      <= IDLE;
                            abort_pend <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            state     <= LAUNCH;
                            eng_start <= 1'b1;
                        end
                    end else begin
                        arm_cnt <= arm_cnt + ACW'(1);
                    end
                end
                LAUNCH: begin
                    eng_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (eng_done) state <= DRAIN;
                end
                DRAIN: begin
                    if (!hold_valid && (fifo_count == '0)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    eng_n_reset <= 1'b1;
                    eng_start   <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: capture a word, then emit low byte then high byte.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_valid <= 1'b0;
            hold_hi    <= 1'b0;
            hold_word  <= '0;
        end else if (fifo_flush) begin
            hold_valid <= 1'b0;
            hold_hi    <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_hi    <= 1'b0;
            hold_word  <= ad_data;
        end else if (fifo_push) begin
            if (hold_hi) begin
                hold_valid <= 1'b0;
                hold_hi    <= 1'b0;
            end else begin
                hold_hi <= 1'b1;
            end
        end
    end

    // Progress counter (saturating) and sticky data-loss flag, cleared on start.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (start_go) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept && (word_count != '1)) word_count <= word_count + 24'd1;
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cart_dump_ctrl.sv
// Directed-plus-random bench for cart_dump_ctrl with a byte-stream reference model.
module tb_cart_dump_ctrl;

    localparam int FIFO_DEPTH = 16;
    localparam int ARM_CYCLES = 4;
    // With the sink stalled, the FIFO absorbs DEPTH/2 words and the holding register one more.
    localparam int STALL_CAPACITY = FIFO_DEPTH / 2 + 1;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        cmd_start;
    logic        cmd_abort;
    logic        eng_n_reset;
    logic        eng_start;
    logic        eng_data_ready;
    logic        eng_done;
    logic [15:0] ad_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [23:0] word_count;

    cart_dump_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ARM_CYCLES (ARM_CYCLES)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .eng_n_reset    (eng_n_reset),
        .eng_start      (eng_start),
        .eng_data_ready (eng_data_ready),
        .eng_done       (eng_done),
        .ad_data        (ad_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          stall_viol = 0;
    int          tx_mode = 0;
    int          rx_base = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [15:0] w;
    logic [15:0] ws[13];

    // Sink monitor: record accepted bytes and watch data stability under stall.
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && tx_valid && (tx_data !== prev_data)) stall_viol <= stall_viol + 1;
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (tx_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            2:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_n(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic send_word(input logic [15:0] word);
        eng_data_ready = 1'b1;
        ad_data        = word;
        step();
        eng_data_ready = 1'b0;
        ad_data        = 16'($urandom);
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic expect_word(input logic [15:0] word);
        exp_q.push_back(word[7:0]);
        exp_q.push_back(word[15:8]);
    endtask

    task automatic arm_check(input logic exp_launch);
        int low;
        low = 0;
        while ((eng_n_reset === 1'b0) && (low < 20)) begin
            low++;
            step();
        end
        chk("arm_low_width", low, ARM_CYCLES);
        chk("launch_pulse", eng_start, exp_launch);
        step();
        chk("launch_end", eng_start, 1'b0);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while ((done !== 1'b1) && (n < limit)) begin
            step();
            n++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic check_stream(input string tag);
        int got;
        got = rx_q.size() - rx_base;
        chk({tag, "_len"}, got, exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < got); i++)
            chk({tag, "_byte"}, rx_q[rx_base + i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eng_n_reset"}, eng_n_reset, 1'b1);
        chk({tag, "_eng_start"}, eng_start, 1'b0);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_word_count"}, word_count, 24'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset        = 1'b0;
        cmd_start      = 1'b0;
        cmd_abort      = 1'b0;
        eng_data_ready = 1'b0;
        eng_done       = 1'b0;
        ad_data        = '0;
        tx_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b1;
        step();
        check_reset_outputs("reset");

        // Normal dump of three directed words with an always-ready sink.
        tx_mode = 1;
        exp_q.delete();
        rx_base = rx_q.size();
        pulse_start();
        chk("start_busy", busy, 1'b1);
        arm_check(1'b1);
        ws[0] = 16'h1234;
        ws[1] = 16'hABCD;
        ws[2] = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            send_word(ws[i]);
            expect_word(ws[i]);
            wait_n(99);
        end
        eng_done = 1'b1;
        wait_done(200);
        eng_done = 1'b0;
        check_stream("normal");
        chk("normal_count", word_count, 24'd3);
        chk("normal_overflow", overflow, 1'b0);
        chk("normal_busy", busy, 1'b0);
        send_word(16'hBEEF);
        wait_n(3);
        chk("idle_strobe_count", word_count, 24'd3);
        chk("idle_strobe_tx", tx_valid, 1'b0);

        // Backpressure: sink stalled while twelve words arrive.
        tx_mode = 0;
        exp_q.delete();
        rx_base = rx_q.size();
        pulse_start();
        chk("restart_count_zero", word_count, 24'd0);
        chk("restart_done_low", done, 1'b0);
        arm_check(1'b1);
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            send_word(w);
            if (i < STALL_CAPACITY) expect_word(w);
            wait_n(5);
        end
        wait_n(4);
        chk("ovf_count", word_count, STALL_CAPACITY);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_tx_valid", tx_valid, 1'b1);
        chk("ovf_head", tx_data, exp_q[0]);
        eng_done = 1'b1;
        wait_n(10);
        chk("drain_waits_done", done, 1'b0);
        chk("drain_waits_busy", busy, 1'b1);
        tx_mode = 1;
        wait_done(100);
        eng_done = 1'b0;
        check_stream("ovf_drain");

        // Restart from DONE with a toggling sink and random spacing/data.
        tx_mode = 2;
        exp_q.delete();
        rx_base = rx_q.size();
        pulse_start();
        chk("restart_clears_count", word_count, 24'd0);
        chk("restart_clears_ovf", overflow, 1'b0);
        arm_check(1'b1);
        ws[0] = 16'h1234;
        ws[1] = 16'hABCD;
        ws[2] = 16'h00FF;
        for (int i = 3; i < 13; i++) ws[i] = 16'($urandom);
        for (int i = 0; i < 13; i++) begin
            send_word(ws[i]);
            expect_word(ws[i]);
            wait_n($urandom_range(7, 14));
        end
        eng_done = 1'b1;
        wait_done(300);
        eng_done = 1'b0;
        check_stream("toggle");
        chk("toggle_count", word_count, 24'd13);
        chk("toggle_overflow", overflow, 1'b0);
        chk("stall_stability", stall_viol, 0);

        // Abort with bytes queued behind a stalled sink.
        tx_mode = 0;
        pulse_start();
        arm_check(1'b1);
        rx_base = rx_q.size();
        send_word(16'($urandom));
        wait_n(5);
        send_word(16'($urandom));
        step();
        chk("pre_abort_tx_valid", tx_valid, 1'b1);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("abort_flush", tx_valid, 1'b0);
        chk("abort_rearm", eng_n_reset, 1'b0);
        arm_check(1'b0);
        chk("abort_idle_busy", busy, 1'b0);
        chk("abort_idle_done", done, 1'b0);
        chk("abort_count", word_count, 24'd2);
        chk("abort_overflow", overflow, 1'b0);
        tx_mode = 1;
        wait_n(20);
        chk("abort_no_tx", rx_q.size() - rx_base, 0);
        chk("abort_tx_valid", tx_valid, 1'b0);

        // Asynchronous reset between clock edges in the middle of a dump.
        tx_mode = 0;
        pulse_start();
        arm_check(1'b1);
        send_word(16'h5A5A);
        wait_n(3);
        chk("pre_reset_count", word_count, 24'd1);
        chk("pre_reset_tx_valid", tx_valid, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        n_reset = 1'b1;
        step();
        chk("post_reset_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
